k12a_ram_ctrl: RTL

Synchronous controller for the 32 KiB asynchronous 62256-style SRAM. It arbitrates between two requesters: port A (CPU) and port B (loader/DMA). For each granted access it sequences `ram_ce_n`, `ram_oe_n`, `ram_we_n`, the address and the bidirectional data bus through setup, strobe and hold phases, with a programmable strobe length. It sits between the core's memory stage and the SRAM pins.

---
 rtl/k12a_ram_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/k12a_ram_ctrl.sv
// Two-port arbiter and strobe sequencer for a 62256-style asynchronous SRAM.
// Each access runs IDLE -> SETUP -> STROBE x WAIT_CYCLES -> HOLD.
module k12a_ram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [14:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [14:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic [14:0] ram_addr,
  inout  wire  [7:0]  ram_data,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        busy
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("k12a_ram_ctrl: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        gnt_b_q, gnt_b_d;
  logic        last_b_q, last_b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_rdata_q, a_rdata_d;
  logic [7:0]  b_rdata_q, b_rdata_d;
  logic        pick_b;
  logic        drive;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      gnt_b_q   <= gnt_b_d;
      last_b_q  <= last_b_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_b_d   = gnt_b_q;
    last_b_d  = last_b_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    // On a tie, B wins only if A was granted last.
    pick_b    = b_req && (!a_req || !last_b_q);
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_b_d  = pick_b;
          last_b_d = pick_b;
          we_d     = pick_b ? b_we    : a_we;
          addr_d   = pick_b ? b_addr  : a_addr;
          wdata_d  = pick_b ? b_wdata : a_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = WaitLoad;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          if (!we_q) begin
            if (gnt_b_q) b_rdata_d = ram_data;
            else         a_rdata_d = ram_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin controls decode straight from registered state, so reset releases them at once.
  assign busy     = (state_q != IDLE);
  assign ram_ce_n = (state_q == IDLE);
  assign ram_oe_n = !(!we_q && (state_q == SETUP || state_q == STROBE));
  assign ram_we_n = !(we_q && state_q == STROBE);
  assign drive    = we_q && (state_q != IDLE);
  assign ram_data = drive ? wdata_q : 8'hzz;
  assign ram_addr = addr_q;
  assign a_ack    = (state_q == HOLD) && !gnt_b_q;
  assign b_ack    = (state_q == HOLD) &&  gnt_b_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule
